// File: rtl/dual_fifo_pkg.sv
// Shared types and constants for the dual FIFO controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dual_fifo_pkg;

    localparam int   FIFO_DW = 9;
    localparam logic SIDE_A  = 1'b0;
    localparam logic SIDE_B  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        WR,
        RD,
        RECOVER
    } state_e;

endpackage

// File: rtl/flag_sync.sv
// Multi-flop synchronizer for one asynchronous FIFO flag.
// Latency: DEPTH clocks from pin change to sync_o.
// Backpressure: none; free-running.
module flag_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_,
    input  logic async_i,
    output logic sync_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the raw flag through DEPTH flops; reset to the safe value for this flag.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_i};
        end
    end

    assign sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/dual_fifo_ctl.sv
// Sequences write, read and reset strobes for a dual 1024x9 asynchronous FIFO, one operation at a time.
// Latency: wr_ack STROBE_CYC+1 clocks after grant; rd_valid STROBE_CYC+1 clocks after read grant.
// Backpressure: wr_req held until wr_ack; a buffered read word blocks further reads until rd_ready.
module dual_fifo_ctl
    import dual_fifo_pkg::*;
#(
    parameter int STROBE_CYC = 3,
    parameter int ACCESS_CYC = 2,
    parameter int RS_CYC     = 4,
    parameter int FLAG_SYNC  = 2
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               flush,
    input  logic               wr_req_a,
    input  logic               wr_req_b,
    input  logic [FIFO_DW-1:0] wr_data_a,
    input  logic [FIFO_DW-1:0] wr_data_b,
    output logic               wr_ack_a,
    output logic               wr_ack_b,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FIFO_DW-1:0] rd_data,
    output logic               rd_src,
    output logic               busy,
    output logic [FIFO_DW-1:0] DA,
    output logic [FIFO_DW-1:0] DB,
    output logic               WA_,
    output logic               WB_,
    output logic               RA_,
    output logic               RB_,
    output logic               RSA_,
    output logic               RSB_,
    input  logic               EFA_,
    input  logic               EFB_,
    input  logic               FFA_,
    input  logic               FFB_,
    input  logic [FIFO_DW-1:0] QA,
    input  logic [FIFO_DW-1:0] QB
);

    // One shared counter times strobes, reset pulses and recovery; 8 bits covers all sane settings.
    localparam int CW = 8;
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] ACC_LAST = CW'(ACCESS_CYC - 1);
    localparam logic [CW-1:0] RS_LAST  = CW'(RS_CYC - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(FLAG_SYNC);

    logic efa_s, efb_s, ffa_s, ffb_s;

    // Empty flags reset to "empty" and full flags to "not full" so nothing is strobed before the pins settle.
    flag_sync #(.DEPTH(FLAG_SYNC), .RST_VAL(1'b0)) u_sync_efa (.clk(clk), .rst_(rst_), .async_i(EFA_), .sync_o(efa_s));
    flag_sync #(.DEPTH(FLAG_SYNC), .RST_VAL(1'b0)) u_sync_efb (.clk(clk), .rst_(rst_), .async_i(EFB_), .sync_o(efb_s));
    flag_sync #(.DEPTH(FLAG_SYNC), .RST_VAL(1'b1)) u_sync_ffa (.clk(clk), .rst_(rst_), .async_i(FFA_), .sync_o(ffa_s));
    flag_sync #(.DEPTH(FLAG_SYNC), .RST_VAL(1'b1)) u_sync_ffb (.clk(clk), .rst_(rst_), .async_i(FFB_), .sync_o(ffb_s));

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              side_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic              flush_pend_q;
    logic              wa_n_q, wb_n_q, ra_n_q, rb_n_q, rs_n_q;
    logic [FIFO_DW-1:0] da_q, db_q, rd_data_q;
    logic              wr_ack_a_q, wr_ack_b_q;
    logic              rd_valid_q, rd_src_q, busy_q;

    logic wr_el_a, wr_el_b, rd_el_a, rd_el_b;
    logic wr_sel, rd_sel;

    // Eligibility and round-robin choice; the pointer only matters when both halves qualify.
    always_comb begin
        wr_el_a = wr_req_a && ffa_s;
        wr_el_b = wr_req_b && ffb_s;
        rd_el_a = efa_s && !rd_valid_q;
        rd_el_b = efb_s && !rd_valid_q;
        wr_sel  = (wr_el_a && wr_el_b) ? wr_ptr_q : (wr_el_b ? SIDE_B : SIDE_A);
        rd_sel  = (rd_el_a && rd_el_b) ? rd_ptr_q : (rd_el_b ? SIDE_B : SIDE_A);
    end

    // Controller FSM: every pin-facing output is a register written here.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q      <= RST;
            cnt_q        <= '0;
            side_q       <= SIDE_A;
            wr_ptr_q     <= SIDE_A;
            rd_ptr_q     <= SIDE_A;
            flush_pend_q <= 1'b0;
            wa_n_q       <= 1'b1;
            wb_n_q       <= 1'b1;
            ra_n_q       <= 1'b1;
            rb_n_q       <= 1'b1;
            rs_n_q       <= 1'b0;
            da_q         <= '0;
            db_q         <= '0;
            wr_ack_a_q   <= 1'b0;
            wr_ack_b_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_src_q     <= SIDE_A;
            busy_q       <= 1'b1;
        end else begin
            wr_ack_a_q <= 1'b0;
            wr_ack_b_q <= 1'b0;
            if (rd_valid_q && rd_ready) begin
                rd_valid_q <= 1'b0;
            end
            // A flush during an operation waits for it to finish; strobes are never cut short.
            if (flush && (state_q == WR || state_q == RD || state_q == RECOVER)) begin
                flush_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (flush || flush_pend_q) begin
                        state_q      <= RST;
                        cnt_q        <= '0;
                        rs_n_q       <= 1'b0;
                        rd_valid_q   <= 1'b0;
                        wr_ptr_q     <= SIDE_A;
                        rd_ptr_q     <= SIDE_A;
                        flush_pend_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else if (wr_el_a || wr_el_b) begin
                        state_q  <= WR;
                        cnt_q    <= '0;
                        side_q   <= wr_sel;
                        wr_ptr_q <= ~wr_sel;
                        busy_q   <= 1'b1;
                        if (wr_sel == SIDE_A) begin
                            da_q   <= wr_data_a;
                            wa_n_q <= 1'b0;
                        end else begin
                            db_q   <= wr_data_b;
                            wb_n_q <= 1'b0;
                        end
                    end else if (rd_el_a || rd_el_b) begin
                        state_q  <= RD;
                        cnt_q    <= '0;
                        side_q   <= rd_sel;
                        rd_ptr_q <= ~rd_sel;
                        busy_q   <= 1'b1;
                        if (rd_sel == SIDE_A) begin
                            ra_n_q <= 1'b0;
                        end else begin
                            rb_n_q <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                RST: begin
                    // A further flush while resetting simply restarts the pulse.
                    if (flush) begin
                        cnt_q <= '0;
                    end else if (cnt_q == RS_LAST) begin
                        state_q <= RECOVER;
                        cnt_q   <= '0;
                        rs_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WR: begin
                    if (cnt_q == STB_LAST) begin
                        state_q    <= RECOVER;
                        cnt_q      <= '0;
                        wa_n_q     <= 1'b1;
                        wb_n_q     <= 1'b1;
                        wr_ack_a_q <= (side_q == SIDE_A);
                        wr_ack_b_q <= (side_q == SIDE_B);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD: begin
                    if (cnt_q == ACC_LAST) begin
                        rd_data_q <= (side_q == SIDE_B) ? QB : QA;
                        rd_src_q  <= side_q;
                    end
                    if (cnt_q == STB_LAST) begin
                        state_q    <= RECOVER;
                        cnt_q      <= '0;
                        ra_n_q     <= 1'b1;
                        rb_n_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RECOVER: begin
                    // Give the synchronized flags time to reflect the operation just done.
                    if (cnt_q == REC_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RECOVER;
                    cnt_q   <= '0;
                    wa_n_q  <= 1'b1;
                    wb_n_q  <= 1'b1;
                    ra_n_q  <= 1'b1;
                    rb_n_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign WA_      = wa_n_q;
    assign WB_      = wb_n_q;
    assign RA_      = ra_n_q;
    assign RB_      = rb_n_q;
    assign RSA_     = rs_n_q;
    assign RSB_     = rs_n_q;
    assign DA       = da_q;
    assign DB       = db_q;
    assign wr_ack_a = wr_ack_a_q;
    assign wr_ack_b = wr_ack_b_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_src   = rd_src_q;
    assign busy     = busy_q;

endmodule
